// File: rtl/io_pkg.sv
// Shared constants and types for the memory-mapped I/O responder at 0xC000-0xC007.
// Offsets, base decode value, FSM state encoding and status bit positions live here.
package io_pkg;

  localparam logic [12:0] IO_BASE = 13'h1800;

  localparam logic [2:0] OFS_LED     = 3'd0;
  localparam logic [2:0] OFS_SWITCH  = 3'd1;
  localparam logic [2:0] OFS_TCOUNT  = 3'd2;
  localparam logic [2:0] OFS_TCTRL   = 3'd3;
  localparam logic [2:0] OFS_TCMP    = 3'd4;
  localparam logic [2:0] OFS_KDATA   = 3'd5;
  localparam logic [2:0] OFS_KSTATUS = 3'd6;

  typedef logic [0:0] io_state_t;
  localparam io_state_t ST_IDLE = 1'b0;
  localparam io_state_t ST_ACK  = 1'b1;

  localparam int KS_NOT_EMPTY = 0;
  localparam int KS_FULL      = 1;
  localparam int KS_OVERFLOW  = 2;

  localparam int TC_ENABLE = 0;
  localparam int TC_FLAG   = 1;

endpackage

// File: rtl/io_fifo.sv
// Small synchronous FIFO holding keyboard scan codes for the I/O responder.
// A pop of a non-empty FIFO frees a slot, so a push is accepted when full if it coincides with a pop.
module io_fifo #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       full,
  output logic       empty
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   cnt;
  logic          do_push;
  logic          do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == (AW+1)'(FIFO_DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (do_push) wptr <= (wptr == AW'(FIFO_DEPTH-1)) ? '0 : wptr + 1'b1;
      if (do_pop)  rptr <= (rptr == AW'(FIFO_DEPTH-1)) ? '0 : rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/io_responder.sv
// Memory-mapped I/O responder: LEDs, switches, optional timer and key FIFO at 0xC000-0xC007.
// Define IO_TIMER_EN to build the timer; otherwise offsets 2-4 read 0 and irq is tied low.
module io_responder
  import io_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memread,
  input  logic        memwrite,
  input  logic [15:0] adr,
  input  logic [15:0] writedata,
  output logic [15:0] iodata,
  output logic        ioready,
  output logic [15:0] led,
  input  logic [15:0] sw,
  input  logic        key_valid,
  input  logic [7:0]  key_code,
  output logic        irq
);

  io_state_t   state;
  logic        hit;
  logic        access;
  logic        wr_en;
  logic        rd_en;
  logic [2:0]  ofs;
  logic [15:0] sw_meta;
  logic [15:0] sw_sync;
  logic [15:0] rdata;
  logic [15:0] key_status;
  logic [7:0]  key_head;
  logic        key_full;
  logic        key_empty;
  logic        key_pop;
  logic        overflow;
  logic [15:0] timer_count_rd;
  logic [15:0] timer_ctrl_rd;
  logic [15:0] timer_cmp_rd;

  // Accesses arriving while acknowledging are dropped; a simultaneous read+write is a write.
  assign hit     = (adr[15:3] == IO_BASE);
  assign ofs     = adr[2:0];
  assign access  = (memread | memwrite) & hit & (state == ST_IDLE);
  assign wr_en   = access & memwrite;
  assign rd_en   = access & memread & ~memwrite;
  assign ioready = (state == ST_ACK);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  state <= ST_IDLE;
    else if (state == ST_ACK) state <= ST_IDLE;
    else if (access)          state <= ST_ACK;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sw_meta <= '0;
      sw_sync <= '0;
    end else begin
      sw_meta <= sw;
      sw_sync <= sw_meta;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                             led <= '0;
    else if (wr_en && ofs == OFS_LED)    led <= writedata;
  end

  assign key_pop = rd_en && (ofs == OFS_KDATA) && !key_empty;

  io_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (key_valid),
    .pop   (key_pop),
    .wdata (key_code),
    .rdata (key_head),
    .full  (key_full),
    .empty (key_empty)
  );

  // A dropped push in the same cycle as a software clear keeps the overflow bit set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      overflow <= 1'b0;
    else if (key_valid && key_full && !key_pop)
      overflow <= 1'b1;
    else if (wr_en && ofs == OFS_KSTATUS && writedata[KS_OVERFLOW])
      overflow <= 1'b0;
  end

`ifdef IO_TIMER_EN
  logic [15:0] t_count;
  logic [15:0] t_cmp;
  logic        t_en;
  logic        t_flag;
  logic        t_match;

  assign t_match = t_en && (t_count == t_cmp);

  // Writing the compare value restarts the count; a match set beats a software clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      t_count <= '0;
      t_cmp   <= '0;
      t_en    <= 1'b0;
      t_flag  <= 1'b0;
    end else begin
      if (wr_en && ofs == OFS_TCMP) begin
        t_cmp   <= writedata;
        t_count <= '0;
      end else if (t_en) begin
        t_count <= t_match ? '0 : t_count + 1'b1;
      end
      if (wr_en && ofs == OFS_TCTRL) t_en <= writedata[TC_ENABLE];
      if (t_match)
        t_flag <= 1'b1;
      else if (wr_en && ofs == OFS_TCTRL && writedata[TC_FLAG])
        t_flag <= 1'b0;
    end
  end

  assign irq            = t_flag;
  assign timer_count_rd = t_count;
  assign timer_cmp_rd   = t_cmp;
  assign timer_ctrl_rd  = {14'h0000, t_flag, t_en};
`else
  assign irq            = 1'b0;
  assign timer_count_rd = '0;
  assign timer_cmp_rd   = '0;
  assign timer_ctrl_rd  = '0;
`endif

  always_comb begin
    key_status               = '0;
    key_status[KS_NOT_EMPTY] = ~key_empty;
    key_status[KS_FULL]      = key_full;
    key_status[KS_OVERFLOW]  = overflow;
  end

  always_comb begin
    rdata = '0;
    case (ofs)
      OFS_LED:     rdata = led;
      OFS_SWITCH:  rdata = sw_sync;
      OFS_TCOUNT:  rdata = timer_count_rd;
      OFS_TCTRL:   rdata = timer_ctrl_rd;
      OFS_TCMP:    rdata = timer_cmp_rd;
      OFS_KDATA:   rdata = key_empty ? 16'h0000 : {8'h00, key_head};
      OFS_KSTATUS: rdata = key_status;
      default:     rdata = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        iodata <= '0;
    else if (rd_en) iodata <= rdata;
  end

endmodule

// File: tb/tb_io_responder.sv
// Self-checking bench for io_responder: table of single accesses plus hand-written
// sequences for ACK-time accesses, key FIFO overflow/full push+pop, timer and reset mid-access.
module tb_io_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        memread;
  logic        memwrite;
  logic [15:0] adr;
  logic [15:0] writedata;
  logic [15:0] iodata;
  logic        ioready;
  logic [15:0] led;
  logic [15:0] sw;
  logic        key_valid;
  logic [7:0]  key_code;
  logic        irq;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [15:0] adr;
    logic [15:0] wdata;
    logic        exp_ack;
    logic [15:0] exp_iodata;
    logic [15:0] exp_led;
  } vec_t;

  vec_t vecs[13];

  io_responder #(.FIFO_DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .memread   (memread),
    .memwrite  (memwrite),
    .adr       (adr),
    .writedata (writedata),
    .iodata    (iodata),
    .ioready   (ioready),
    .led       (led),
    .sw        (sw),
    .key_valid (key_valid),
    .key_code  (key_code),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Presents one strobe across a single rising edge and returns 1 ns after it.
  task automatic applyStimulus(input logic rd, input logic wr, input logic [15:0] a, input logic [15:0] wd);
    memread   = rd;
    memwrite  = wr;
    adr       = a;
    writedata = wd;
    @(posedge clk); #1;
    memread  = 1'b0;
    memwrite = 1'b0;
  endtask

  task automatic access(input string name, input logic rd, input logic wr, input logic [15:0] a,
                        input logic [15:0] wd, input logic exp_ack, input logic [15:0] exp_iodata);
    checkOutput({name, " ready_before"}, {15'h0, ioready}, 16'h0);
    applyStimulus(rd, wr, a, wd);
    checkOutput({name, " ready"}, {15'h0, ioready}, {15'h0, exp_ack});
    checkOutput({name, " iodata"}, iodata, exp_iodata);
    @(posedge clk); #1;
    checkOutput({name, " ready_after"}, {15'h0, ioready}, 16'h0);
  endtask

  task automatic pushKey(input logic [7:0] code);
    key_valid = 1'b1;
    key_code  = code;
    @(posedge clk); #1;
    key_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; memread = 0; memwrite = 0; adr = 0; writedata = 0;
    sw = 16'h0000; key_valid = 0; key_code = 0;

    vecs[0]  = '{1'b0, 1'b1, 16'hC000, 16'h00A5, 1'b1, 16'h0000, 16'h00A5};
    vecs[1]  = '{1'b1, 1'b0, 16'hC000, 16'h0000, 1'b1, 16'h00A5, 16'h00A5};
    vecs[2]  = '{1'b1, 1'b0, 16'hC001, 16'h0000, 1'b1, 16'h1234, 16'h00A5};
    vecs[3]  = '{1'b1, 1'b0, 16'h8000, 16'h0000, 1'b0, 16'h1234, 16'h00A5};
    vecs[4]  = '{1'b1, 1'b0, 16'hC008, 16'h0000, 1'b0, 16'h1234, 16'h00A5};
    vecs[5]  = '{1'b0, 1'b1, 16'h8000, 16'hFFFF, 1'b0, 16'h1234, 16'h00A5};
    vecs[6]  = '{1'b1, 1'b1, 16'hC000, 16'h5A5A, 1'b1, 16'h1234, 16'h5A5A};
    vecs[7]  = '{1'b1, 1'b0, 16'hC007, 16'h0000, 1'b1, 16'h0000, 16'h5A5A};
    vecs[8]  = '{1'b0, 1'b1, 16'hC007, 16'hFFFF, 1'b1, 16'h0000, 16'h5A5A};
    vecs[9]  = '{1'b1, 1'b0, 16'hC000, 16'h0000, 1'b1, 16'h5A5A, 16'h5A5A};
    vecs[10] = '{1'b1, 1'b0, 16'hC006, 16'h0000, 1'b1, 16'h0000, 16'h5A5A};
    vecs[11] = '{1'b1, 1'b0, 16'hC000, 16'h0000, 1'b1, 16'h5A5A, 16'h5A5A};
    vecs[12] = '{1'b1, 1'b0, 16'hC005, 16'h0000, 1'b1, 16'h0000, 16'h5A5A};

    #12;
    checkOutput("reset ioready", {15'h0, ioready}, 16'h0);
    checkOutput("reset iodata", iodata, 16'h0000);
    checkOutput("reset led", led, 16'h0000);
    checkOutput("reset irq", {15'h0, irq}, 16'h0);
    @(negedge clk); rst = 1'b0;

    // Switches need two edges through the synchronizer before a read sees them.
    sw = 16'h1234;
    @(posedge clk); @(posedge clk); #1;

    $display("[TB] table-driven accesses");
    for (int i = 0; i < 13; i++) begin
      access($sformatf("vec%0d", i), vecs[i].rd, vecs[i].wr, vecs[i].adr, vecs[i].wdata,
             vecs[i].exp_ack, vecs[i].exp_iodata);
      checkOutput($sformatf("vec%0d led", i), led, vecs[i].exp_led);
    end

    $display("[TB] access held into ACK is ignored");
    memwrite = 1'b1; adr = 16'hC000; writedata = 16'h1111;
    @(posedge clk); #1;
    checkOutput("hold led first", led, 16'h1111);
    checkOutput("hold ready first", {15'h0, ioready}, 16'h1);
    writedata = 16'h2222;
    @(posedge clk); #1;
    checkOutput("hold led in ack", led, 16'h1111);
    checkOutput("hold ready second", {15'h0, ioready}, 16'h0);
    memwrite = 1'b0;
    @(posedge clk); #1;

    $display("[TB] key FIFO overflow");
    pushKey(8'h11); pushKey(8'h22); pushKey(8'h33); pushKey(8'h44); pushKey(8'h55);
    access("status full ovf", 1, 0, 16'hC006, 0, 1, 16'h0007);
    access("key0", 1, 0, 16'hC005, 0, 1, 16'h0011);
    access("key1", 1, 0, 16'hC005, 0, 1, 16'h0022);
    access("key2", 1, 0, 16'hC005, 0, 1, 16'h0033);
    access("key3", 1, 0, 16'hC005, 0, 1, 16'h0044);
    access("key empty", 1, 0, 16'hC005, 0, 1, 16'h0000);
    access("status ovf only", 1, 0, 16'hC006, 0, 1, 16'h0004);
    access("clear ovf", 0, 1, 16'hC006, 16'h0004, 1, 16'h0004);
    access("status cleared", 1, 0, 16'hC006, 0, 1, 16'h0000);

    $display("[TB] push and pop together while full");
    pushKey(8'hA1); pushKey(8'hA2); pushKey(8'hA3); pushKey(8'hA4);
    key_valid = 1'b1; key_code = 8'hA5;
    applyStimulus(1, 0, 16'hC005, 0);
    key_valid = 1'b0;
    checkOutput("pushpop iodata", iodata, 16'h00A1);
    @(posedge clk); #1;
    access("pushpop status", 1, 0, 16'hC006, 0, 1, 16'h0003);
    access("pp key1", 1, 0, 16'hC005, 0, 1, 16'h00A2);
    access("pp key2", 1, 0, 16'hC005, 0, 1, 16'h00A3);
    access("pp key3", 1, 0, 16'hC005, 0, 1, 16'h00A4);
    access("pp key4", 1, 0, 16'hC005, 0, 1, 16'h00A5);
    access("pp status empty", 1, 0, 16'hC006, 0, 1, 16'h0000);

`ifdef IO_TIMER_EN
    $display("[TB] timer match and flag clear");
    access("tcmp write", 0, 1, 16'hC004, 16'h0005, 1, 16'h0000);
    access("tctrl enable", 0, 1, 16'hC003, 16'h0001, 1, 16'h0000);
    checkOutput("irq at count1", {15'h0, irq}, 16'h0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      checkOutput($sformatf("irq low step%0d", i), {15'h0, irq}, 16'h0);
    end
    @(posedge clk); #1;
    checkOutput("irq on match", {15'h0, irq}, 16'h1);
    access("tctrl read flag", 1, 0, 16'hC003, 0, 1, 16'h0003);
    applyStimulus(0, 1, 16'hC003, 16'h0003);
    checkOutput("irq cleared", {15'h0, irq}, 16'h0);
    @(posedge clk); #1;
    access("tctrl still enabled", 1, 0, 16'hC003, 0, 1, 16'h0001);
`else
    $display("[TB] timer omitted");
    access("tcmp write", 0, 1, 16'hC004, 16'h0005, 1, 16'h0000);
    access("tctrl write", 0, 1, 16'hC003, 16'h0003, 1, 16'h0000);
    access("tcmp read", 1, 0, 16'hC004, 0, 1, 16'h0000);
    access("led read", 1, 0, 16'hC000, 0, 1, 16'h1111);
    access("tctrl read", 1, 0, 16'hC003, 0, 1, 16'h0000);
    access("led read2", 1, 0, 16'hC000, 0, 1, 16'h1111);
    access("tcount read", 1, 0, 16'hC002, 0, 1, 16'h0000);
    checkOutput("irq tied low", {15'h0, irq}, 16'h0);
`endif

    $display("[TB] reset during ACK");
    pushKey(8'h77);
    applyStimulus(0, 1, 16'hC000, 16'h1234);
    checkOutput("pre-reset ready", {15'h0, ioready}, 16'h1);
    #2 rst = 1'b1;
    #1;
    checkOutput("rst ready", {15'h0, ioready}, 16'h0);
    checkOutput("rst led", led, 16'h0000);
    checkOutput("rst iodata", iodata, 16'h0000);
    checkOutput("rst irq", {15'h0, irq}, 16'h0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    checkOutput("post-rst ready idle", {15'h0, ioready}, 16'h0);
    access("post-rst write", 0, 1, 16'hC000, 16'h0042, 1, 16'h0000);
    checkOutput("post-rst led", led, 16'h0042);
    access("post-rst led read", 1, 0, 16'hC000, 0, 1, 16'h0042);
    access("post-rst status", 1, 0, 16'hC006, 0, 1, 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/io_responder.md
IO_RESPONDER -- requirements
Module: io_responder

Interface
REQ-001 SHALL have port clk, input, 1, sole clock, all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-003 SHALL have ports memread / memwrite, input, 1 each, CPU access strobes.
REQ-004 SHALL have ports adr (16) and writedata (16), inputs, CPU address and store data.
REQ-005 SHALL have ports iodata (16) and ioready (1), outputs, load data and one-cycle access acknowledge.
REQ-006 SHALL have ports led (16) output, sw (16) input, key_valid (1) input, key_code (8) input, and irq (1) output.
REQ-007 SHALL have parameter FIFO_DEPTH, default 4, power of two, key FIFO entries.

Function
REQ-008 SHALL respond only when adr[15:3]==13'h1800, i.e. 0xC000-0xC007; all other addresses are ignored, with no ioready.
REQ-009 SHALL use a map of 0 LED (RW), 1 SWITCH (RO), 2 TIMER_COUNT (RO), 3 TIMER_CTRL, 4 TIMER_CMP (RW), 5 KEY_DATA (RO, pop), 6 KEY_STATUS, 7 unmapped (reads 0, writes ignored).
REQ-010 SHALL use an FSM with IDLE and ACK states: IDLE->ACK on a decoded access sampled at the edge, ACK->IDLE unconditionally, and ignore accesses presented in ACK.
REQ-011 SHALL give stores a latency of zero: the register updates on the sampling edge and ioready goes high for exactly the following cycle.
REQ-012 SHALL capture load data into iodata on the sampling edge, assert ioready for one cycle, and hold iodata until the next load.
REQ-013 SHALL treat memread and memwrite both high as a write only.
REQ-014 SHALL pass sw through a 2-flop synchronizer; SWITCH reads return the synchronized value.
REQ-015 SHALL make TIMER_CTRL bit0 enable (RW) and bit1 match flag (write-1-clear); irq equals the match flag.
REQ-016 SHALL, when enabled, increment TIMER_COUNT each cycle; when count==TIMER_CMP, the next count is 0 and the flag is set.
REQ-017 SHALL let flag set win over a simultaneous software clear.
REQ-018 SHALL clear the count when TIMER_CMP is written.
REQ-019 SHALL push key_code into the FIFO on key_valid high; if the FIFO is full with no pop that cycle, the push is dropped and the sticky overflow bit is set.
REQ-020 SHALL, on a KEY_DATA read, return {8'h00, head} and pop; an empty-FIFO read returns 16'h0000 with no pop.
REQ-021 SHALL accept push and pop in the same cycle when full, with no overflow and unchanged occupancy.
REQ-022 SHALL make KEY_STATUS bit0 not-empty, bit1 full, bit2 overflow (write-1-clear), other bits 0.

Reset
REQ-023 SHALL, on rst, asynchronously set FSM=IDLE, iodata=0, ioready=0, led=0, timer count/cmp/ctrl=0, irq=0, FIFO empty, overflow=0, synchronizer=0.
REQ-024 SHALL abandon any in-flight ACK on reset mid-access with no ioready pulse; the first access after release is handled normally.

Configuration
REQ-025 SHALL, with IO_TIMER_EN defined, build the timer as specified.
REQ-026 SHALL, without IO_TIMER_EN, omit the timer logic: addresses 2-4 read 0, writes to them are ignored, and irq is tied 0.

Structure
REQ-027 SHALL place address-offset constants, the base constant 13'h1800, the FSM state typedef, and KEY_STATUS bit positions in package io_pkg.
REQ-028 SHALL implement the key FIFO as sub-module io_fifo (parameter FIFO_DEPTH, 8-bit data, push/pop/full/empty).

Verification
REQ-029 SHALL cover: write 0x00A5 to 0xC000 -> led==0x00A5 same edge, ioready high one cycle next.
REQ-030 SHALL cover: sw=0x1234, wait 2 cycles, read 0xC001 -> iodata==0x1234 with ioready one cycle after strobe.
REQ-031 SHALL cover: CMP=5, CTRL=1 -> count 0..5 then 0, irq rises; write CTRL=0x3 -> irq clears, timer stays enabled.
REQ-032 SHALL cover: push 0x11,0x22,0x33,0x44,0x55 -> overflow set, status=0x0007; reads return 0x0011..0x0044, then 0x0000.
REQ-033 SHALL cover: memread at 0x8000 or 0xC008 -> no ioready, iodata unchanged; memread and memwrite together at 0xC000 -> write only.
REQ-034 SHALL cover: rst asserted during ACK -> ioready low immediately, all registers at reset values.
